// File: rtl/sraccum_if.sv
// Stream bundle for sraccum: operand input channel and result output channel.
interface sraccum_if #(
  parameter int unsigned COUNT_W = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_sum;
  logic [COUNT_W-1:0] out_count;
  logic               out_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_err
  );
endinterface

// File: rtl/sraccum.sv
// Streaming single-precision same-sign accumulator with valid/ready result port.
// Optional SRACCUM_SIGNCHK_EN: reject (and flag) terms whose sign differs from the acc.
module sraccum #(
  parameter int unsigned COUNT_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  sraccum_if.slave  bus
);
  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [31:0] NaN = 32'hFFFF_FFFF;

  state_e             r_state;
  logic [31:0]        r_acc;
  logic [COUNT_W-1:0] r_cnt;
  logic               r_err;

  state_e             w_state_nxt;
  logic [31:0]        w_acc_nxt;
  logic [COUNT_W-1:0] w_cnt_nxt;
  logic               w_err_nxt;
  logic               w_accept;

  // Adder datapath
  logic [7:0]  w_ea, w_eb, w_emax, w_diff, w_eres;
  logic        w_a_zero, w_b_zero, w_a_big;
  logic [23:0] w_mbig, w_msmall;
  logic [24:0] w_msum;
  logic [22:0] w_mres;
  logic [31:0] w_sum;
  logic        w_ovf;
  logic        w_sign_bad;

  assign w_accept     = bus.in_valid && bus.in_ready;
  assign bus.in_ready = (r_state != StDone);
  assign bus.out_valid = (r_state == StDone);
  assign bus.out_sum   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_err   = r_err;

  always_comb begin
    w_ea     = r_acc[30:23];
    w_eb     = bus.in_data[30:23];
    w_a_zero = (w_ea == 8'd0);
    w_b_zero = (w_eb == 8'd0);
    w_a_big  = (w_ea >= w_eb);
    w_emax   = w_a_big ? w_ea : w_eb;
    w_diff   = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
    w_mbig   = w_a_big ? {1'b1, r_acc[22:0]} : {1'b1, bus.in_data[22:0]};
    w_msmall = w_a_big ? {1'b1, bus.in_data[22:0]} : {1'b1, r_acc[22:0]};
    w_msum   = {1'b0, w_mbig} + {1'b0, (w_msmall >> w_diff)};
    w_eres   = w_emax;
    w_mres   = w_msum[22:0];
    w_ovf    = 1'b0;
    w_sum    = r_acc;
    if (w_a_zero) begin
      w_sum = bus.in_data;
    end else if (w_b_zero) begin
      w_sum = r_acc;
    end else if (w_diff > 8'd22) begin
      w_sum = w_a_big ? r_acc : bus.in_data;
    end else begin
      if (w_msum[24]) begin
        w_eres = w_emax + 8'd1;
        w_mres = w_msum[23:1];
      end
      // 8-bit exponent wraps past 255, so a smaller result exponent also means overflow
      w_ovf = (w_eres == 8'hFF) || (w_eres < w_emax);
      w_sum = {r_acc[31], w_eres, w_mres};
    end
  end

`ifdef SRACCUM_SIGNCHK_EN
  assign w_sign_bad = (r_acc[31] != bus.in_data[31]) && !w_a_zero && !w_b_zero;
`else
  assign w_sign_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_acc_nxt   = bus.in_data;
          w_cnt_nxt   = COUNT_W'(1);
          w_err_nxt   = 1'b0;
          w_state_nxt = bus.in_last ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (w_accept) begin
          w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + COUNT_W'(1);
          if (r_acc == NaN) begin
            w_acc_nxt = r_acc;
          end else if (w_sign_bad) begin
            w_err_nxt = 1'b1;
          end else if (w_ovf) begin
            w_acc_nxt = NaN;
            w_err_nxt = 1'b1;
          end else begin
            w_acc_nxt = w_sum;
          end
          if (bus.in_last) w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_acc   <= 32'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end
endmodule

// File: doc/sraccum.md
# sraccum

Streaming single-precision accumulator that sits directly upstream of the FFT output stage. It feeds the combinational same-sign adder `sradd`. Each accepted operand is summed with a running accumulator register, one term per clock. When a term marked `in_last` is accepted, the block presents the total, term count and error flag on a valid/ready output port.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the term counter; the counter saturates at 2^COUNT_W−1.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset, synchronous, active-low.
- `in_valid`: input, 1 bit. Input operand valid.
- `in_ready`: output, 1 bit. Block can accept an operand.
- `in_data`: input, 32 bits. IEEE-754 SP operand, no denormals/inf.
- `in_last`: input, 1 bit. Marks the final term of the current sum.
- `out_valid`: output, 1 bit. Result valid.
- `out_ready`: input, 1 bit. Consumer accepts the result.
- `out_sum`: output, 32 bits. Accumulated SP sum.
- `out_count`: output, COUNT_W bits. Number of terms accepted in this sum.
- `out_err`: output, 1 bit. Sticky error for this sum.

## Operation
- States:
  - IDLE: accumulator empty.
  - ACCUM: at least one term held, `last` not yet seen.
  - DONE: result presented.
- Accept condition: `in_valid && in_ready`. `in_ready = (state != DONE)`.
- IDLE on accept:
  - acc ← in_data; count ← 1; err ← 0.
  - Go to DONE if `in_last`, else ACCUM.
- ACCUM on accept:
  - acc ← sradd(acc, in_data); count ← count+1, saturating.
  - Go to DONE if `in_last`.
- Adder rules (`sradd`, combinational):
  - A zero operand returns the other operand.
  - If the exponent difference is greater than 22, the larger-exponent operand is returned.
  - Otherwise the mantissas (hidden one restored) are aligned and summed. On carry out, the sum is renormalised by one bit and the exponent incremented.
  - Truncation, no rounding. Result sign = sign of acc.
- Overflow: if the adder result exponent is 8'hFF, or is less than max(acc exp, in exp) (wrap):
  - acc ← 32'hFFFFFFFF (NaN); err ← 1.
  - Later terms leave a NaN acc unchanged.
- DONE: `out_valid=1`, with `out_sum`=acc, `out_count`=count, `out_err`=err. On `out_ready`, go to IDLE.
- `in_data` = 32'h0 is a legal term: it counts and leaves acc unchanged.

## Timing
- Reset (`rst_n`=0 at a clock edge): state=IDLE; acc=0; count=0; err=0; `out_valid`=0; `out_sum`=0; `out_count`=0; `out_err`=0; `in_ready`=1 from the next cycle. Reset mid-sum discards all partial state.
- Throughput: one term per cycle in IDLE/ACCUM.
- Latency: `in_last` accepted at edge N → `out_valid`=1 after edge N (visible in cycle N+1).
- Outputs are registered and held stable while `out_valid && !out_ready`. `in_ready`=0 for that whole interval.
- Result handshake at edge M → `in_ready`=1 and `out_valid`=0 in cycle M+1. The next operand can be accepted at edge M+1; there is no same-cycle pass-through.
- Count saturation: at 2^COUNT_W−1 the counter holds. Further terms are still summed and do not set err.

## Configuration
- `SRACCUM_SIGNCHK_EN`, defined (sign check on):
  - In ACCUM, a term whose sign differs from acc's sign, with both values non-zero, is not added.
  - acc is unchanged, count still increments, err ← 1.
- `SRACCUM_SIGNCHK_EN`, undefined:
  - No check. Mismatched terms are added as magnitudes and keep acc's sign.
  - err is set only by overflow.

## Test plan
- Three terms 3F800000, 3F800000, 40000000 (last on the third) → `out_sum`=40800000 (4.0), `out_count`=3, `out_err`=0, `out_valid` one cycle after the last accept.
- Two terms BF800000, BF800000(last) → `out_sum`=C0000000, `out_count`=2, `out_err`=0.
- With `SRACCUM_SIGNCHK_EN`: 3F800000, BF800000(last) → `out_sum`=3F800000, `out_count`=2, `out_err`=1. Without the macro → `out_sum`=40000000, `out_err`=0.
- Single term 00000000 with last → `out_sum`=00000000, `out_count`=1. Then hold `out_ready`=0 for 3 cycles → `out_valid`, `out_sum` and `out_count` stable and `in_ready`=0 throughout; IDLE one cycle after `out_ready`=1.
- Overflow: 7F000000, 7F000000(last) → `out_sum`=FFFFFFFF, `out_err`=1.
- Reset mid-sum: accept 3F800000, assert `rst_n`=0 for one edge, then 40000000(last) → `out_sum`=40000000, `out_count`=1.
